// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle control FSM and the MIPS datapath.
// The controller is the master: it reads the opcode and memory handshake and
// drives every datapath select, strobe and status line.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       OpCode;
  logic             MemReady;
  logic             Halt;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             Halted;
  logic             Trap;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstrRetired;

  modport master (
    input  OpCode, MemReady, Halt,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Halted, Trap, State, InstrRetired
  );

  modport slave (
    output OpCode, MemReady, Halt,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Halted, Trap, State, InstrRetired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control. A Moore FSM emits one control word per
// state; only IRWrite/PCWrite in FETCH follow MemReady combinationally so the
// IR and PC load exactly in the cycle the instruction word arrives.
// Illegal opcodes either park in TRAP or fall through as a NOP, a Halt
// request is honoured only at instruction boundaries, and completed
// instructions are counted.
module multicycle_control #(
  parameter int CNT_W           = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_HALT    = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t           state;
  state_t           state_next;
  logic             end_instr;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;

  // Retired-instruction count wraps naturally at 2^CNT_W.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  // State register; reset wins over every input, including TRAP and waits.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Retired-instruction counter, bumped on the last cycle of each real instruction.
  always_ff @(posedge clk) begin
    if (reset)       retired_cnt <= '0;
    else if (retire) retired_cnt <= wrap_inc(retired_cnt);
  end

  // Next-state decode; every path back to FETCH goes through the Halt check.
  always_comb begin
    state_next = state;
    end_instr  = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH:   if (bus.MemReady) state_next = S_DECODE;
      S_DECODE: begin
        case (bus.OpCode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EX;
          default: begin
            // An illegal NOP ends the instruction but is not counted.
            if (TRAP_ON_ILLEGAL) state_next = S_TRAP;
            else                 end_instr  = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_next = (bus.OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (bus.MemReady) state_next = S_MEMWB;
      S_MEMWB: begin
        end_instr = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWR: begin
        if (bus.MemReady) begin
          end_instr = 1'b1;
          retire    = 1'b1;
        end
      end
      S_EXEC:    state_next = S_RWB;
      S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        end_instr = 1'b1;
        retire    = 1'b1;
      end
      S_ADDI_EX: state_next = S_ADDI_WB;
      S_HALT:    if (!bus.Halt) state_next = S_FETCH;
      S_TRAP:    state_next = S_TRAP;
      default:   state_next = S_FETCH;
    endcase
    if (end_instr) state_next = bus.Halt ? S_HALT : S_FETCH;
  end

  // Per-state control word; everything not named in a state stays 0.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.Halted      = 1'b0;
    bus.Trap        = 1'b0;
    case (state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
      end
      S_DECODE:  bus.ALUSrcB = 2'b11;
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      S_ADDI_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_ADDI_WB: bus.RegWrite = 1'b1;
      S_HALT:    bus.Halted   = 1'b1;
      S_TRAP:    bus.Trap     = 1'b1;
      default: ;
    endcase
  end

  assign bus.State        = state;
  assign bus.InstrRetired = retired_cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a trapping CNT_W=4 instance and a NOP-on-illegal
// CNT_W=32 instance run side by side against an instruction-sequence model.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] op [2];
  logic       mr [2];
  logic       hl [2];
  logic       rs [2];

  multicycle_control_if #(.CNT_W(4))  ifa ();
  multicycle_control_if #(.CNT_W(32)) ifb ();

  assign ifa.OpCode   = op[0];
  assign ifa.MemReady = mr[0];
  assign ifa.Halt     = hl[0];
  assign ifb.OpCode   = op[1];
  assign ifb.MemReady = mr[1];
  assign ifb.Halt     = hl[1];

  multicycle_control #(.CNT_W(4), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(rs[0]), .bus(ifa));
  multicycle_control #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(rs[1]), .bus(ifb));

  logic [17:0] word_a, word_b;
  assign word_a = {ifa.PCWrite, ifa.PCWriteCond, ifa.IorD, ifa.MemRead, ifa.MemWrite,
                   ifa.IRWrite, ifa.MemtoReg, ifa.RegDst, ifa.RegWrite, ifa.ALUSrcA,
                   ifa.ALUSrcB, ifa.ALUOp, ifa.PCSource, ifa.Halted, ifa.Trap};
  assign word_b = {ifb.PCWrite, ifb.PCWriteCond, ifb.IorD, ifb.MemRead, ifb.MemWrite,
                   ifb.IRWrite, ifb.MemtoReg, ifb.RegDst, ifb.RegWrite, ifb.ALUSrcA,
                   ifb.ALUSrcB, ifb.ALUOp, ifb.PCSource, ifb.Halted, ifb.Trap};

  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_TRAP = 2;

  int          n_checks = 0;
  int          n_errors = 0;
  int          mode [2];
  int          pos  [2];
  logic [31:0] cnt  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
           o == 6'b000100 || o == 6'b000010 || o == 6'b001000;
  endfunction

  // State visited at step i of an instruction; -1 once the instruction is over.
  function automatic int seq_of(input int k, input logic [5:0] o, input int i);
    int s[$];
    case (o)
      6'b000000: s = '{0, 1, 6, 7};
      6'b100011: s = '{0, 1, 2, 3, 4};
      6'b101011: s = '{0, 1, 2, 5};
      6'b000100: s = '{0, 1, 8};
      6'b000010: s = '{0, 1, 9};
      6'b001000: s = '{0, 1, 10, 11};
      default:   if (k == 0) s = '{0, 1, 13}; else s = '{0, 1};
    endcase
    return (i < s.size()) ? s[i] : -1;
  endfunction

  // Control word per state as listed in the datasheet table.
  function automatic logic [17:0] ctrl_word(input int st, input logic rdy);
    logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, hlt, trp;
    logic [1:0] asb, aop, psrc;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, hlt, trp} = '0;
    asb = 2'd0; aop = 2'd0; psrc = 2'd0;
    case (st)
      0:  begin mrd = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'd2; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'd1; pcc = 1; psrc = 2'd1; end
      9:  begin pcw = 1; psrc = 2'd2; end
      10: begin asa = 1; asb = 2'd2; end
      11: rw = 1;
      12: hlt = 1;
      13: trp = 1;
      default: ;
    endcase
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, hlt, trp};
  endfunction

  function automatic int exp_state(input int k);
    if (mode[k] == M_HALT) return 12;
    if (mode[k] == M_TRAP) return 13;
    return seq_of(k, op[k], pos[k]);
  endfunction

  task automatic model_step(input int k);
    int cur, nxt;
    if (rs[k]) begin
      mode[k] = M_RUN; pos[k] = 0; cnt[k] = 0;
      return;
    end
    if (mode[k] == M_HALT) begin
      if (!hl[k]) begin mode[k] = M_RUN; pos[k] = 0; end
    end else if (mode[k] == M_RUN) begin
      cur = seq_of(k, op[k], pos[k]);
      if (!((cur == 0 || cur == 3 || cur == 5) && !mr[k])) begin
        nxt = seq_of(k, op[k], pos[k] + 1);
        if (nxt < 0) begin
          if (cur != 1) cnt[k] = (k == 0) ? ((cnt[k] + 1) & 32'hF) : (cnt[k] + 1);
          pos[k] = 0;
          if (hl[k]) mode[k] = M_HALT;
        end else if (nxt == 13) begin
          mode[k] = M_TRAP;
        end else begin
          pos[k] = pos[k] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    check("a.state", 32'(ifa.State), 32'(exp_state(0)));
    check("a.ctrl",  32'(word_a),    32'(ctrl_word(exp_state(0), mr[0])));
    check("a.count", 32'(ifa.InstrRetired), cnt[0]);
    check("b.state", 32'(ifb.State), 32'(exp_state(1)));
    check("b.ctrl",  32'(word_b),    32'(ctrl_word(exp_state(1), mr[1])));
    check("b.count", ifb.InstrRetired, cnt[1]);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic r, input logic h, input logic x);
    for (int k = 0; k < 2; k++) begin
      op[k] = o; mr[k] = r; hl[k] = h; rs[k] = x;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [5:0] pick_op();
    int r;
    logic [5:0] o;
    r = $urandom_range(0, 31);
    if (r < 4)       o = 6'b000000;
    else if (r < 10) o = 6'b100011;
    else if (r < 15) o = 6'b101011;
    else if (r < 19) o = 6'b000100;
    else if (r < 23) o = 6'b000010;
    else if (r < 31) o = 6'b001000;
    else begin
      o = 6'($urandom_range(0, 63));
      if (is_legal(o)) o = 6'b111111;
    end
    return o;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_RUN; pos[k] = 0; cnt[k] = 0;
    end
    drive(6'b001000, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    drive(6'b001000, 1'b1, 1'b0, 1'b0);
    check("reset.state", 32'(ifa.State), 32'd0);
    check("reset.count", ifb.InstrRetired, 32'd0);

    // 17 addi: the 4-bit counter wraps back to 1
    cycles(68);
    check("wrap.count4", 32'(ifa.InstrRetired), 32'd1);
    check("wrap.count32", ifb.InstrRetired, 32'd17);

    // lw with three wait cycles in MEMRD
    drive(6'b100011, 1'b1, 1'b0, 1'b0); cycles(3);
    drive(6'b100011, 1'b0, 1'b0, 1'b0); cycles(3);
    check("lw.wait_iord", 32'(ifa.IorD), 32'd1);
    drive(6'b100011, 1'b1, 1'b0, 1'b0); cycles(2);
    check("lw.count", ifb.InstrRetired, 32'd18);

    // beq then j
    drive(6'b000100, 1'b1, 1'b0, 1'b0); cycles(2);
    check("beq.pcwritecond", 32'(ifa.PCWriteCond), 32'd1);
    cycles(1);
    drive(6'b000010, 1'b1, 1'b0, 1'b0); cycles(2);
    check("j.pcsource", 32'(ifa.PCSource), 32'd2);
    cycles(1);
    check("bj.count", ifb.InstrRetired, 32'd20);

    // Halt raised during EXEC does not cut the R-type short
    drive(6'b000000, 1'b1, 1'b0, 1'b0); cycles(2);
    drive(6'b000000, 1'b1, 1'b1, 1'b0); cycles(2);
    check("halt.halted", 32'(ifa.Halted), 32'd1);
    check("halt.count", ifb.InstrRetired, 32'd21);
    cycles(1);
    drive(6'b000000, 1'b1, 1'b0, 1'b0); cycles(1);
    check("halt.resume", 32'(ifa.State), 32'd0);

    // Illegal opcode: trap instance parks, NOP instance keeps fetching
    drive(6'b111111, 1'b1, 1'b0, 1'b0); cycles(22);
    check("trap.flag", 32'(ifa.Trap), 32'd1);
    check("nop.count", ifb.InstrRetired, 32'd21);
    drive(6'b111111, 1'b1, 1'b0, 1'b1); cycles(1);
    drive(6'b101011, 1'b1, 1'b0, 1'b0);
    check("trap.reset_flag", 32'(ifa.Trap), 32'd0);

    // Reset during a MEMWR wait
    cycles(3);
    drive(6'b101011, 1'b0, 1'b0, 1'b0); cycles(2);
    check("sw.wait_write", 32'(ifa.MemWrite), 32'd1);
    drive(6'b101011, 1'b0, 1'b0, 1'b1); cycles(1);
    drive(6'b101011, 1'b0, 1'b0, 1'b0);
    check("swrst.write", 32'(ifa.MemWrite), 32'd0);
    check("swrst.count", 32'(ifa.InstrRetired), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (mode[k] != M_RUN || pos[k] == 0) op[k] = pick_op();
        mr[k] = ($urandom_range(0, 9) < 7);
        hl[k] = ($urandom_range(0, 19) == 0);
        rs[k] = ($urandom_range(0, 149) == 0);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM that sequences the team's MIPS datapath as a multi-cycle machine. The single-cycle control decode is replaced by per-state control words.
- Sits beside the datapath. It takes the fetched opcode and a memory-ready handshake, and drives every mux select, write enable and ALUOp the datapath needs.
- Also traps illegal opcodes, supports a halt request, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TRAP_ON_ILLEGAL, 1: 1 = illegal opcode enters TRAP; 0 = illegal opcode is treated as a NOP and returns to FETCH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- OpCode  input  6  Instruction[31:26] from the instruction register.
- MemReady  input  1  memory completes the current access this cycle.
- Halt  input  1  request to stop at the next instruction boundary.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU zero (branch).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  write register select: 0 = rt, 1 = rd.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extend, 11 = sign-extend<<2.
- ALUOp  output  2  00 = add, 01 = sub, 10 = use funct field.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- Halted  output  1  FSM parked in HALT.
- Trap  output  1  FSM parked in TRAP.
- State  output  4  current state encoding (debug).
- InstrRetired  output  CNT_W  count of completed instructions.

Behaviour:
- Opcodes decoded: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. All others are illegal.
- States and encodings, with control word listed; unlisted outputs are 0:
  - FETCH(0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite are asserted only in the cycle MemReady=1. Stays in FETCH while MemReady=0.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode: lw/sw→MEMADR, R-type→EXEC, beq→BRANCH, j→JUMP, addi→ADDI_EX, illegal→TRAP (or FETCH if TRAP_ON_ILLEGAL=0).
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw→MEMRD, sw→MEMWR.
  - MEMRD(3): MemRead, IorD=1. Held until MemReady=1, then →MEMWB.
  - MEMWB(4): RegWrite, MemtoReg=1, RegDst=0. Then →FETCH.
  - MEMWR(5): MemWrite, IorD=1. Held until MemReady=1, then →FETCH.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then →RWB.
  - RWB(7): RegWrite, RegDst=1, MemtoReg=0. Then →FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01. Then →FETCH.
  - JUMP(9): PCWrite, PCSource=10. Then →FETCH.
  - ADDI_EX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Then →ADDI_WB.
  - ADDI_WB(11): RegWrite, RegDst=0, MemtoReg=0. Then →FETCH.
  - HALT(12): Halted=1, all strobes 0. Returns to FETCH when Halt=0.
  - TRAP(13): Trap=1, all strobes 0. Exits only on reset.
- Outputs are combinational from State (Moore), except IRWrite and PCWrite in FETCH, which are gated by MemReady.
- Latency with MemReady tied high: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles. Each wait cycle adds 1.
- MemRead/MemWrite/IorD stay stable throughout a wait.
- Halt is sampled only on transitions into FETCH (the last state of an instruction): Halt=1 diverts to HALT instead of FETCH. Halt asserted mid-instruction never truncates that instruction.
- InstrRetired increments by 1 on leaving MEMWB, MEMWR (when MemReady=1), RWB, BRANCH, JUMP or ADDI_WB. It wraps modulo 2^CNT_W. An illegal-opcode NOP with TRAP_ON_ILLEGAL=0 does not count.
- Reset has priority over every other input, including mid-wait and in TRAP. It sets State=FETCH, InstrRetired=0, Halted=0, Trap=0. All strobes deassert the cycle after reset is sampled, apart from the FETCH word.

Test Plan:
- Reset, then MemReady=1, R-type opcode 000000 → FETCH,DECODE,EXEC,RWB; RegWrite=1 with RegDst=1 only in cycle 4; InstrRetired=1.
- lw (100011) with MemReady low for 3 cycles in MEMRD → MemRead/IorD=1 held for 4 cycles; MEMWB asserts RegWrite and MemtoReg; 8 cycles total.
- beq (000100) then j (000010) → PCWriteCond=1, PCSource=01, ALUOp=01 in cycle 3; then PCWrite=1, PCSource=10 in cycle 3 of the jump; InstrRetired=2.
- Opcode 111111, TRAP_ON_ILLEGAL=1 → TRAP in cycle 3, Trap=1, no strobes for 20 cycles; reset → FETCH, Trap=0.
- Halt raised during EXEC of an R-type → RWB completes; enters HALT, Halted=1; drop Halt → FETCH next cycle.
- CNT_W=4, 17 addi instructions → InstrRetired=1 after wrap; reset asserted mid-MEMWR wait → FETCH, counter 0, MemWrite=0.
